// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares the register file between the processor and a test/debug master.
// The processor is stalled, its last write is allowed to drain, and then the
// arbiter either serves single test transactions over a valid/ready handshake
// or dumps every register two at a time through read ports A and B.
// Optional build macro: ARB_WRITE_PROTECT_EN (blocks test writes to r0 and
// reports them on t_err).
module regfile_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_ctrl_writeEnable,
  input  logic [ADDR_W-1:0] p_ctrl_writeReg,
  input  logic [ADDR_W-1:0] p_ctrl_readRegA,
  input  logic [ADDR_W-1:0] p_ctrl_readRegB,
  input  logic [DATA_W-1:0] p_data_writeReg,
  output logic              proc_stall,
  input  logic              t_req,
  input  logic              t_valid,
  output logic              t_ready,
  input  logic              t_we,
  input  logic [ADDR_W-1:0] t_addr,
  input  logic [DATA_W-1:0] t_wdata,
  output logic              t_rvalid,
  output logic [DATA_W-1:0] t_rdata,
  input  logic              dump_start,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_dataA,
  output logic [DATA_W-1:0] dump_dataB,
  output logic              dump_busy,
  output logic              r_ctrl_writeEnable,
  output logic [ADDR_W-1:0] r_ctrl_writeReg,
  output logic [ADDR_W-1:0] r_ctrl_readRegA,
  output logic [ADDR_W-1:0] r_ctrl_readRegB,
  output logic [DATA_W-1:0] r_data_writeReg,
  input  logic [DATA_W-1:0] r_data_readRegA,
  input  logic [DATA_W-1:0] r_data_readRegB
`ifdef ARB_WRITE_PROTECT_EN
  ,
  output logic              t_err
`endif
);

  typedef enum logic [1:0] {
    PROC  = 2'd0,
    DRAIN = 2'd1,
    TEST  = 2'd2,
    DUMP  = 2'd3
  } arbState_t;

  localparam logic [ADDR_W-1:0] kLast = ADDR_W'(NUM_REGS / 2 - 1);

  arbState_t         state;
  arbState_t         nextState;
  arbState_t         target;
  arbState_t         nextTarget;
  logic              stallReg;
  logic [ADDR_W-1:0] kCount;
  logic [ADDR_W-1:0] dumpAddrA;
  logic [ADDR_W-1:0] dumpAddrB;
  logic              accept;
  logic              acceptWrite;
  logic              acceptRead;
  logic              writeBlocked;
  logic              forwardWrite;

  assign dumpAddrA    = kCount << 1;
  assign dumpAddrB    = dumpAddrA | ADDR_W'(1);
  assign accept       = (state == TEST) && t_valid;
  assign acceptWrite  = accept && t_we;
  assign acceptRead   = accept && !t_we;
`ifdef ARB_WRITE_PROTECT_EN
  assign writeBlocked = acceptWrite && (t_addr == '0);
`else
  assign writeBlocked = 1'b0;
`endif
  assign forwardWrite = acceptWrite && !writeBlocked;

  assign t_ready    = (state == TEST);
  assign dump_busy  = (state == DUMP);
  assign proc_stall = stallReg;

  // Next-state logic: PROC always drains first, dump_start beats t_req.
  always_comb begin
    nextState  = state;
    nextTarget = target;
    case (state)
      PROC: begin
        if (dump_start) begin
          nextState  = DRAIN;
          nextTarget = DUMP;
        end else if (t_req) begin
          nextState  = DRAIN;
          nextTarget = TEST;
        end
      end
      DRAIN: nextState = target;
      TEST: begin
        if (dump_start) begin
          nextState = DUMP;
        end else if (!t_req && !t_valid) begin
          nextState = PROC;
        end
      end
      DUMP: begin
        if (kCount == kLast) begin
          nextState = t_req ? TEST : PROC;
        end
      end
      default: nextState = PROC;
    endcase
  end

  // Regfile port mux: processor owns the ports in PROC/DRAIN, the arbiter otherwise.
  always_comb begin
    r_ctrl_writeEnable = p_ctrl_writeEnable;
    r_ctrl_writeReg    = p_ctrl_writeReg;
    r_ctrl_readRegA    = p_ctrl_readRegA;
    r_ctrl_readRegB    = p_ctrl_readRegB;
    r_data_writeReg    = p_data_writeReg;
    case (state)
      TEST: begin
        r_ctrl_writeEnable = forwardWrite;
        r_ctrl_writeReg    = t_addr;
        r_data_writeReg    = t_wdata;
        r_ctrl_readRegA    = t_addr;
        r_ctrl_readRegB    = t_addr;
      end
      DUMP: begin
        r_ctrl_writeEnable = 1'b0;
        r_ctrl_readRegA    = dumpAddrA;
        r_ctrl_readRegB    = dumpAddrB;
      end
      default: ;
    endcase
  end

  // State, drain target, registered stall and the dump pair counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= PROC;
      target   <= TEST;
      stallReg <= 1'b0;
      kCount   <= '0;
    end else begin
      state    <= nextState;
      target   <= nextTarget;
      stallReg <= (nextState != PROC);
      if (state == DUMP) begin
        kCount <= (kCount == kLast) ? '0 : kCount + ADDR_W'(1);
      end else begin
        kCount <= '0;
      end
    end
  end

  // Registered test read data and dump beats, one cycle behind the regfile read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t_rvalid   <= 1'b0;
      t_rdata    <= '0;
      dump_valid <= 1'b0;
      dump_index <= '0;
      dump_dataA <= '0;
      dump_dataB <= '0;
    end else begin
      t_rvalid   <= acceptRead;
      if (acceptRead) begin
        t_rdata <= r_data_readRegA;
      end
      dump_valid <= (state == DUMP);
      if (state == DUMP) begin
        dump_index <= dumpAddrA;
        dump_dataA <= r_data_readRegA;
        dump_dataB <= r_data_readRegB;
      end
    end
  end

`ifdef ARB_WRITE_PROTECT_EN
  // One-cycle error pulse after a blocked write to r0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t_err <= 1'b0;
    end else begin
      t_err <= writeBlocked;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter
// Directed bench for regfile_port_arbiter with a small behavioural regfile
// (combinational reads, r0 reads as zero). Define ARB_WRITE_PROTECT_EN to
// exercise the r0 write-protect build.
module tb_regfile_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clock;
  logic              reset;
  logic              p_ctrl_writeEnable;
  logic [ADDR_W-1:0] p_ctrl_writeReg;
  logic [ADDR_W-1:0] p_ctrl_readRegA;
  logic [ADDR_W-1:0] p_ctrl_readRegB;
  logic [DATA_W-1:0] p_data_writeReg;
  logic              proc_stall;
  logic              t_req;
  logic              t_valid;
  logic              t_ready;
  logic              t_we;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  logic              t_rvalid;
  logic [DATA_W-1:0] t_rdata;
  logic              dump_start;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_index;
  logic [DATA_W-1:0] dump_dataA;
  logic [DATA_W-1:0] dump_dataB;
  logic              dump_busy;
  logic              r_ctrl_writeEnable;
  logic [ADDR_W-1:0] r_ctrl_writeReg;
  logic [ADDR_W-1:0] r_ctrl_readRegA;
  logic [ADDR_W-1:0] r_ctrl_readRegB;
  logic [DATA_W-1:0] r_data_writeReg;
  logic [DATA_W-1:0] r_data_readRegA;
  logic [DATA_W-1:0] r_data_readRegB;
`ifdef ARB_WRITE_PROTECT_EN
  logic              t_err;
`endif

  logic              modelClear;
  logic [DATA_W-1:0] regs [0:31];
  int                checks;
  int                errors;

  regfile_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
    .clock(clock), .reset(reset),
    .p_ctrl_writeEnable(p_ctrl_writeEnable), .p_ctrl_writeReg(p_ctrl_writeReg),
    .p_ctrl_readRegA(p_ctrl_readRegA), .p_ctrl_readRegB(p_ctrl_readRegB),
    .p_data_writeReg(p_data_writeReg), .proc_stall(proc_stall),
    .t_req(t_req), .t_valid(t_valid), .t_ready(t_ready), .t_we(t_we),
    .t_addr(t_addr), .t_wdata(t_wdata), .t_rvalid(t_rvalid), .t_rdata(t_rdata),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_index(dump_index),
    .dump_dataA(dump_dataA), .dump_dataB(dump_dataB), .dump_busy(dump_busy),
    .r_ctrl_writeEnable(r_ctrl_writeEnable), .r_ctrl_writeReg(r_ctrl_writeReg),
    .r_ctrl_readRegA(r_ctrl_readRegA), .r_ctrl_readRegB(r_ctrl_readRegB),
    .r_data_writeReg(r_data_writeReg), .r_data_readRegA(r_data_readRegA),
    .r_data_readRegB(r_data_readRegB)
`ifdef ARB_WRITE_PROTECT_EN
    , .t_err(t_err)
`endif
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Behavioural regfile, r0 is never written.
  always @(posedge clock) begin
    if (modelClear) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (r_ctrl_writeEnable && (r_ctrl_writeReg != '0)) begin
      regs[r_ctrl_writeReg] <= r_data_writeReg;
    end
  end

  assign r_data_readRegA = regs[r_ctrl_readRegA];
  assign r_data_readRegB = regs[r_ctrl_readRegB];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    p_ctrl_writeReg = 5'd6; p_ctrl_readRegA = 5'd2; p_ctrl_readRegB = 5'd3;
    p_data_writeReg = 32'hA5A5;
    #3;
    checks++; if (proc_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0h expected 0", proc_stall); end
    checks++; if (t_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %0h expected 0", t_ready); end
    checks++; if (t_rvalid !== 1'b0 || dump_valid !== 1'b0 || dump_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got rvalid=%0h dvalid=%0h busy=%0h expected 0", t_rvalid, dump_valid, dump_busy); end
    checks++; if (t_rdata !== 32'h0 || dump_dataA !== 32'h0 || dump_dataB !== 32'h0 || dump_index !== 5'd0) begin errors++; $display("[TB] FAIL reset_data: got rdata=%0h A=%0h B=%0h idx=%0h expected 0", t_rdata, dump_dataA, dump_dataB, dump_index); end
    checks++; if (r_ctrl_readRegA !== 5'd2 || r_ctrl_readRegB !== 5'd3) begin errors++; $display("[TB] FAIL reset_passthru: got %0h/%0h expected 2/3", r_ctrl_readRegA, r_ctrl_readRegB); end
    tick; tick;
    modelClear = 1'b0;
    reset = 1'b0;
    tick;
    checks++; if (r_ctrl_writeReg !== 5'd6 || r_data_writeReg !== 32'hA5A5) begin errors++; $display("[TB] FAIL proc_passthru: got %0h/%0h expected 6/a5a5", r_ctrl_writeReg, r_data_writeReg); end
  endtask

  task automatic test_drain;
    t_req = 1'b1; p_ctrl_writeEnable = 1'b1; p_ctrl_writeReg = 5'd3; p_data_writeReg = 32'h1234;
    #1;
    checks++; if (proc_stall !== 1'b0 || r_ctrl_writeEnable !== 1'b1) begin errors++; $display("[TB] FAIL proc_write: got stall=%0h we=%0h expected 0/1", proc_stall, r_ctrl_writeEnable); end
    tick;
    checks++; if (proc_stall !== 1'b1 || t_ready !== 1'b0) begin errors++; $display("[TB] FAIL drain_stall: got stall=%0h ready=%0h expected 1/0", proc_stall, t_ready); end
    p_ctrl_writeReg = 5'd4; p_data_writeReg = 32'h4444;
    #1;
    checks++; if (r_ctrl_writeEnable !== 1'b1 || r_ctrl_writeReg !== 5'd4) begin errors++; $display("[TB] FAIL drain_write: got we=%0h reg=%0h expected 1/4", r_ctrl_writeEnable, r_ctrl_writeReg); end
    tick;
    checks++; if (t_ready !== 1'b1) begin errors++; $display("[TB] FAIL test_ready: got %0h expected 1", t_ready); end
    checks++; if (regs[3] !== 32'h1234 || regs[4] !== 32'h4444) begin errors++; $display("[TB] FAIL drain_regs: got %0h/%0h expected 1234/4444", regs[3], regs[4]); end
    p_ctrl_writeReg = 5'd5; p_data_writeReg = 32'h5555;
    #1;
    checks++; if (r_ctrl_writeEnable !== 1'b0) begin errors++; $display("[TB] FAIL test_drop_we: got %0h expected 0", r_ctrl_writeEnable); end
    tick;
    checks++; if (regs[5] !== 32'h0) begin errors++; $display("[TB] FAIL test_drop_reg: got %0h expected 0", regs[5]); end
    p_ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_back_to_back;
    t_valid = 1'b1; t_we = 1'b1; t_addr = 5'd7; t_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (r_ctrl_writeEnable !== 1'b1 || r_ctrl_writeReg !== 5'd7 || r_data_writeReg !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL tw_ports: got we=%0h reg=%0h data=%0h expected 1/7/deadbeef", r_ctrl_writeEnable, r_ctrl_writeReg, r_data_writeReg); end
    tick;
    t_we = 1'b0;
    #1;
    checks++; if (r_ctrl_readRegA !== 5'd7 || t_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL tr_addr: got addr=%0h rvalid=%0h expected 7/0", r_ctrl_readRegA, t_rvalid); end
    tick;
    checks++; if (t_rvalid !== 1'b1 || t_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL tr_data: got rvalid=%0h rdata=%0h expected 1/deadbeef", t_rvalid, t_rdata); end
    t_valid = 1'b0; t_req = 1'b0;
    #1;
    checks++; if (t_ready !== 1'b1 || proc_stall !== 1'b1) begin errors++; $display("[TB] FAIL tr_hold: got ready=%0h stall=%0h expected 1/1", t_ready, proc_stall); end
    tick;
    checks++; if (proc_stall !== 1'b0 || t_ready !== 1'b0 || t_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL test_exit: got stall=%0h ready=%0h rvalid=%0h expected 0", proc_stall, t_ready, t_rvalid); end
  endtask

  task automatic test_preload;
    t_req = 1'b1;
    tick; tick;
    for (int i = 1; i < 32; i++) begin
      t_valid = 1'b1; t_we = 1'b1; t_addr = 5'(i); t_wdata = 32'(i * 17);
      tick;
    end
    t_valid = 1'b0;
    checks++; if (regs[31] !== 32'h20F || regs[7] !== 32'h77) begin errors++; $display("[TB] FAIL preload: got %0h/%0h expected 20f/77", regs[31], regs[7]); end
  endtask

  task automatic test_dump;
    dump_start = 1'b1;
    tick;
    dump_start = 1'b0; t_req = 1'b0;
    p_ctrl_writeEnable = 1'b1; p_ctrl_writeReg = 5'd9; p_data_writeReg = 32'hBAD;
    for (int k = 0; k < 16; k++) begin
      dump_start = (k == 3);
      #1;
      checks++; if (dump_busy !== 1'b1 || proc_stall !== 1'b1 || r_ctrl_writeEnable !== 1'b0) begin errors++; $display("[TB] FAIL dump_cycle%0d: got busy=%0h stall=%0h we=%0h expected 1/1/0", k, dump_busy, proc_stall, r_ctrl_writeEnable); end
      checks++; if (r_ctrl_readRegA !== 5'(2 * k) || r_ctrl_readRegB !== 5'(2 * k + 1)) begin errors++; $display("[TB] FAIL dump_addr%0d: got %0h/%0h expected %0h/%0h", k, r_ctrl_readRegA, r_ctrl_readRegB, 2 * k, 2 * k + 1); end
      tick;
      dump_start = 1'b0;
      checks++; if (dump_valid !== 1'b1 || dump_index !== 5'(2 * k)) begin errors++; $display("[TB] FAIL dump_beat%0d: got valid=%0h idx=%0h expected 1/%0h", k, dump_valid, dump_index, 2 * k); end
      checks++; if (dump_dataA !== 32'(2 * k * 17) || dump_dataB !== 32'((2 * k + 1) * 17)) begin errors++; $display("[TB] FAIL dump_data%0d: got %0h/%0h expected %0h/%0h", k, dump_dataA, dump_dataB, 2 * k * 17, (2 * k + 1) * 17); end
    end
    p_ctrl_writeEnable = 1'b0;
    checks++; if (dump_busy !== 1'b0 || proc_stall !== 1'b0) begin errors++; $display("[TB] FAIL dump_end: got busy=%0h stall=%0h expected 0/0", dump_busy, proc_stall); end
    tick;
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("[TB] FAIL dump_trail: got %0h expected 0", dump_valid); end
    checks++; if (regs[9] !== 32'h99) begin errors++; $display("[TB] FAIL dump_nowrite: got %0h expected 99", regs[9]); end
  endtask

  task automatic test_dump_then_test;
    dump_start = 1'b1; t_req = 1'b1;
    tick;
    dump_start = 1'b0;
    checks++; if (proc_stall !== 1'b1 || dump_busy !== 1'b0 || t_ready !== 1'b0) begin errors++; $display("[TB] FAIL both_drain: got stall=%0h busy=%0h ready=%0h expected 1/0/0", proc_stall, dump_busy, t_ready); end
    tick;
    for (int k = 0; k < 16; k++) begin
      checks++; if (dump_busy !== 1'b1 || t_ready !== 1'b0 || proc_stall !== 1'b1) begin errors++; $display("[TB] FAIL both_dump%0d: got busy=%0h ready=%0h stall=%0h expected 1/0/1", k, dump_busy, t_ready, proc_stall); end
      tick;
    end
    checks++; if (t_ready !== 1'b1 || dump_busy !== 1'b0 || proc_stall !== 1'b1) begin errors++; $display("[TB] FAIL both_test: got ready=%0h busy=%0h stall=%0h expected 1/0/1", t_ready, dump_busy, proc_stall); end
    checks++; if (dump_valid !== 1'b1 || dump_index !== 5'd30) begin errors++; $display("[TB] FAIL both_lastbeat: got valid=%0h idx=%0h expected 1/1e", dump_valid, dump_index); end
    t_req = 1'b0;
    tick;
    checks++; if (proc_stall !== 1'b0) begin errors++; $display("[TB] FAIL both_exit: got %0h expected 0", proc_stall); end
  endtask

  task automatic test_r0_write;
    t_req = 1'b1;
    tick; tick;
    t_valid = 1'b1; t_we = 1'b1; t_addr = 5'd0; t_wdata = 32'hFFFF;
    #1;
`ifdef ARB_WRITE_PROTECT_EN
    checks++; if (r_ctrl_writeEnable !== 1'b0) begin errors++; $display("[TB] FAIL wp_we: got %0h expected 0", r_ctrl_writeEnable); end
`else
    checks++; if (r_ctrl_writeEnable !== 1'b1) begin errors++; $display("[TB] FAIL r0_we: got %0h expected 1", r_ctrl_writeEnable); end
`endif
    tick;
    t_we = 1'b0;
`ifdef ARB_WRITE_PROTECT_EN
    checks++; if (t_err !== 1'b1) begin errors++; $display("[TB] FAIL wp_err: got %0h expected 1", t_err); end
`endif
    tick;
    t_valid = 1'b0; t_req = 1'b0;
`ifdef ARB_WRITE_PROTECT_EN
    checks++; if (t_err !== 1'b0) begin errors++; $display("[TB] FAIL wp_errpulse: got %0h expected 0", t_err); end
`endif
    checks++; if (t_rvalid !== 1'b1 || t_rdata !== 32'h0) begin errors++; $display("[TB] FAIL r0_read: got rvalid=%0h rdata=%0h expected 1/0", t_rvalid, t_rdata); end
    tick;
  endtask

  task automatic test_reset_mid_dump;
    dump_start = 1'b1;
    tick;
    dump_start = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) tick;
    p_ctrl_readRegA = 5'd12; p_ctrl_readRegB = 5'd13;
    #1;
    checks++; if (r_ctrl_readRegA !== 5'd10 || dump_busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_k5: got addr=%0h busy=%0h expected a/1", r_ctrl_readRegA, dump_busy); end
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick;
    checks++; if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || proc_stall !== 1'b0 || t_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset: got busy=%0h valid=%0h stall=%0h ready=%0h expected 0", dump_busy, dump_valid, proc_stall, t_ready); end
    checks++; if (r_ctrl_readRegA !== 5'd12 || r_ctrl_readRegB !== 5'd13 || dump_index !== 5'd0) begin errors++; $display("[TB] FAIL mid_passthru: got %0h/%0h idx=%0h expected c/d/0", r_ctrl_readRegA, r_ctrl_readRegB, dump_index); end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence.
  initial begin
    checks = 0; errors = 0;
    clock = 1'b0; reset = 1'b1; modelClear = 1'b1;
    p_ctrl_writeEnable = 1'b0; p_ctrl_writeReg = '0; p_ctrl_readRegA = '0;
    p_ctrl_readRegB = '0; p_data_writeReg = '0;
    t_req = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
    dump_start = 1'b0;
    test_reset;
    test_drain;
    test_back_to_back;
    test_preload;
    test_dump;
    test_dump_then_test;
    test_r0_write;
    test_reset_mid_dump;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
